qspi_cmd_queue: RTL and testbench
=================================

QSPI_CMD_QUEUE -- requirements
Module: qspi_cmd_queue

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16): number of buffered requests.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 1024: maximum clk cycles allowed for one QSPI transaction.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port req_valid, input, 1: request beat offered.
REQ-006 SHALL have port req_ready, output, 1: FIFO not full.
REQ-007 SHALL have port req_cmd, input, 3: 1=WHR, 2=WBR, 3=RHR, 4=RBR, 5=WMEM, 6=RMEM.
REQ-008 SHALL have port req_bankmap, input, 8: bank select.
REQ-009 SHALL have port req_addr, input, 32: register or SMEM address.
REQ-010 SHALL have port req_wdata, input, 64: write data.
REQ-011 SHALL have port rsp_valid, output, 1: response beat offered.
REQ-012 SHALL have port rsp_ready, input, 1: response accepted.
REQ-013 SHALL have port rsp_rdata, output, 64: read result.
REQ-014 SHALL have port rsp_err, output, 1: the transaction timed out.
REQ-015 SHALL have ports qspi_cmd (3), qspi_bankmap (8), qspi_addr (32), qspi_wdata (64) and qspi_start (1) as outputs, all driving the QSPI manager request fields.
REQ-016 SHALL have ports qspi_rdata (64) and qspi_idle (1) as inputs, both taken from the QSPI manager response.
REQ-017 SHALL have port err_illegal, output, 1: sticky flag; an illegal command was dropped.
REQ-018 SHALL have port err_timeout, output, 1: sticky flag; a timeout occurred.

Function
REQ-019 SHALL write a request into the FIFO when req_valid&req_ready; req_ready=1 iff occupancy<FIFO_DEPTH.
REQ-020 SHALL accept a push while the FIFO is full if a pop happens in the same cycle; occupancy is unchanged in that case.
REQ-021 SHALL let FIFO pointers wrap modulo FIFO_DEPTH, with an occupancy counter one bit wider than the pointers.
REQ-022 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-023 IDLE: when the FIFO is non-empty and qspi_idle=1, SHALL pop the head, latch its fields onto the qspi_* outputs and go to ISSUE.
REQ-024 IDLE: if the popped command is 0 or 7, SHALL drop it, set err_illegal and stay in IDLE (no start pulse, no response).
REQ-025 ISSUE: SHALL drive qspi_start=1 for exactly one cycle, clear the timeout counter and go to WAIT; qspi_* fields SHALL stay stable until the next pop.
REQ-026 WAIT: on qspi_idle=1, SHALL capture qspi_rdata into rsp_rdata.
REQ-027 WAIT: after that capture, read commands (3,4,6) SHALL go to RESP with rsp_err=0; writes SHALL go to IDLE (see REQ-035).
REQ-028 WAIT: if the counter reaches TIMEOUT_CLKS-1 first, SHALL set err_timeout, set rsp_rdata=64'hFFFF_FFFF_FFFF_FFFF and rsp_err=1, and go to RESP for any command.
REQ-029 RESP: SHALL assert rsp_valid and hold rsp_rdata/rsp_err stable until rsp_ready=1, then go to IDLE.
REQ-030 Latency: the qspi_start pulse SHALL occur exactly 2 cycles after the push into an empty FIFO while idle.
REQ-031 SHALL allow at most one transaction outstanding; order SHALL be preserved.
REQ-032 SHALL keep err_illegal and err_timeout set until reset.

Reset
REQ-033 While reset=1, SHALL empty the FIFO and enter IDLE with req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, qspi_start=0, qspi_cmd=0, qspi_bankmap=0, qspi_addr=0, qspi_wdata=0, err_illegal=0, err_timeout=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no response; req_ready SHALL rise on the first cycle after reset is released.

Configuration
REQ-035 Macro QSPI_WRITE_ACK_EN defined: a completed write SHALL go to RESP with rsp_rdata=0 and rsp_err=0. Undefined: a completed write SHALL return to IDLE with no response beat.

Verification
REQ-036 Push RHR addr=0x04; model returns rdata=0xCCCC_CCCC_3333_3333 after 40 cycles -> one start pulse, qspi_addr=0x04, rsp_valid with that rdata, rsp_err=0.
REQ-037 With qspi_idle held low, push 5 WHR back-to-back -> req_ready falls after the 4th push; 5th accepted once the 1st pops; starts occur in push order.
REQ-038 Push cmd=7, then RHR -> err_illegal=1, no start for cmd 7, RHR issued normally.
REQ-039 Push RMEM, model never returns idle -> after 1024 cycles err_timeout=1, rsp_err=1, rsp_rdata all ones.
REQ-040 Assert reset during WAIT with 3 queued -> no response, FIFO empty, all outputs at reset values.
REQ-041 Push WHR with and without QSPI_WRITE_ACK_EN -> one rsp beat with rdata=0 vs. none.

Source files
------------

// File: rtl/qspi_cmd_queue.sv
// qspi_cmd_queue
//   Buffers QSPI manager requests in a small FIFO and feeds them to the
//   manager one at a time. Reads, and writes when acknowledgements are
//   enabled, return a single response beat. A transaction that does not
//   finish in time is reported as an error response.
//
//   Build option: define QSPI_WRITE_ACK_EN so that completed writes return
//   a response beat (rdata=0, err=0). When it is not defined, completed
//   writes go straight back to idle and return no response.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_ready=1 while the FIFO has room
//   req_cmd               1=WHR 2=WBR 3=RHR 4=RBR 5=WMEM 6=RMEM (0,7 illegal)
//   req_bankmap/addr/wdata request fields
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    read result; rsp_err=1 marks a timed-out transaction
//   qspi_cmd/bankmap/addr/wdata, qspi_start   request to the QSPI manager
//   qspi_rdata, qspi_idle response from the QSPI manager
//   err_illegal           sticky: an illegal command was dropped
//   err_timeout           sticky: a transaction timed out
module qspi_cmd_queue #(
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic [7:0]  req_bankmap,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  qspi_cmd,
    output logic [7:0]  qspi_bankmap,
    output logic [31:0] qspi_addr,
    output logic [63:0] qspi_wdata,
    output logic        qspi_start,
    input  logic [63:0] qspi_rdata,
    input  logic        qspi_idle,
    output logic        err_illegal,
    output logic        err_timeout
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
    localparam int EW = 3 + 8 + 32 + 64;
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CLKS - 1);

`ifdef QSPI_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [TW-1:0]   tmo_cnt;
    logic [EW-1:0]   head;
    logic [2:0]      head_cmd;
    logic            fifo_empty, fifo_full;
    logic            push, pop, issue_load, drop, wait_done, wait_tmo;

    function automatic logic is_read(input logic [2:0] cmd);
        return (cmd == 3'd3) || (cmd == 3'd4) || (cmd == 3'd6);
    endfunction

    assign head       = fifo_mem[rd_ptr];
    assign head_cmd   = head[EW-1 -: 3];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);

    // A full FIFO still takes a beat in the cycle its head is popped.
    assign req_ready  = !reset && (!fifo_full || pop);
    assign push       = req_valid && req_ready;
    assign qspi_start = (state == ISSUE);
    assign rsp_valid  = (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        issue_load = 1'b0;
        drop       = 1'b0;
        wait_done  = 1'b0;
        wait_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && qspi_idle) begin
                    pop = 1'b1;
                    if (head_cmd == 3'd0 || head_cmd == 3'd7) begin
                        drop = 1'b1;
                    end else begin
                        issue_load = 1'b1;
                        state_nxt  = ISSUE;
                    end
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // Completion wins over a timeout landing on the same cycle.
                if (qspi_idle) begin
                    wait_done = 1'b1;
                    state_nxt = (is_read(qspi_cmd) || WRITE_ACK) ? RESP : IDLE;
                end else if (tmo_cnt == TMO_MAX) begin
                    wait_tmo  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage carries no reset; only pointers and occupancy do.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_cmd, req_bankmap, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            tmo_cnt      <= '0;
            qspi_cmd     <= '0;
            qspi_bankmap <= '0;
            qspi_addr    <= '0;
            qspi_wdata   <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            err_illegal  <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (issue_load) begin
                {qspi_cmd, qspi_bankmap, qspi_addr, qspi_wdata} <= head;
            end
            if (drop) begin
                err_illegal <= 1'b1;
            end

            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (wait_done) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= (!is_read(qspi_cmd) && WRITE_ACK) ? 64'd0 : qspi_rdata;
            end
            if (wait_tmo) begin
                err_timeout <= 1'b1;
                rsp_err     <= 1'b1;
                rsp_rdata   <= '1;
            end
        end
    end

endmodule

// File: tb/tb_qspi_cmd_queue.sv
// Directed testbench for qspi_cmd_queue. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_qspi_cmd_queue;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [7:0]  req_bankmap;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  qspi_cmd;
    logic [7:0]  qspi_bankmap;
    logic [31:0] qspi_addr;
    logic [63:0] qspi_wdata;
    logic        qspi_start;
    logic [63:0] qspi_rdata;
    logic        qspi_idle;
    logic        err_illegal;
    logic        err_timeout;

    int n_checks  = 0;
    int n_errors  = 0;
    int start_cnt = 0;
    int base;

`ifdef QSPI_WRITE_ACK_EN
    localparam bit WRITE_ACK = 1'b1;
`else
    localparam bit WRITE_ACK = 1'b0;
`endif

    qspi_cmd_queue #(.FIFO_DEPTH(4), .TIMEOUT_CLKS(1024)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_bankmap(req_bankmap), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .qspi_cmd(qspi_cmd), .qspi_bankmap(qspi_bankmap), .qspi_addr(qspi_addr),
        .qspi_wdata(qspi_wdata), .qspi_start(qspi_start),
        .qspi_rdata(qspi_rdata), .qspi_idle(qspi_idle),
        .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (qspi_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] cmd, input logic [31:0] addr, input logic [63:0] wdata);
        req_valid   = 1'b1;
        req_cmd     = cmd;
        req_bankmap = 8'h5A;
        req_addr    = addr;
        req_wdata   = wdata;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic wait_start(input string tag, input logic [31:0] exp_addr);
        int k = 0;
        while (qspi_start !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_start"}, 64'(qspi_start), 64'd1);
        check({tag, "_addr"}, 64'(qspi_addr), 64'(exp_addr));
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_cmd     = 3'd0;
        req_bankmap = 8'd0;
        req_addr    = 32'd0;
        req_wdata   = 64'd0;
        rsp_ready   = 1'b0;
        qspi_rdata  = 64'd0;
        qspi_idle   = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_qspi_start", 64'(qspi_start), 64'd0);
        check("rst_qspi_cmd", 64'(qspi_cmd), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_err_flags", 64'({err_illegal, err_timeout}), 64'd0);
        reset = 1'b0;
        #1;
        check("rel_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);

        // Single read: start two cycles after the push, response after 40 busy cycles
        push(3'd3, 32'h4, 64'd0);
        check("rd_start_early", 64'(qspi_start), 64'd0);
        tick();
        check("rd_start", 64'(qspi_start), 64'd1);
        check("rd_addr", 64'(qspi_addr), 64'h4);
        check("rd_cmd", 64'(qspi_cmd), 64'd3);
        check("rd_bankmap", 64'(qspi_bankmap), 64'h5A);
        qspi_idle = 1'b0;
        repeat (40) tick();
        check("rd_no_rsp_busy", 64'(rsp_valid), 64'd0);
        qspi_rdata = 64'hCCCC_CCCC_3333_3333;
        qspi_idle  = 1'b1;
        tick();
        check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rd_rsp_rdata", rsp_rdata, 64'hCCCC_CCCC_3333_3333);
        check("rd_rsp_err", 64'(rsp_err), 64'd0);
        tick();
        check("rd_rsp_hold_valid", 64'(rsp_valid), 64'd1);
        check("rd_rsp_hold_rdata", rsp_rdata, 64'hCCCC_CCCC_3333_3333);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd_rsp_done", 64'(rsp_valid), 64'd0);
        check("rd_start_cnt", 64'(start_cnt), 64'd1);

        // Five back-to-back writes against a busy manager
        qspi_idle = 1'b0;
        base = start_cnt;
        for (int i = 0; i < 4; i++) begin
            push(3'd1, 32'h10 + 32'(i), 64'h100 + 64'(i));
        end
        check("full_req_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b1;
        req_cmd   = 3'd1;
        req_addr  = 32'h14;
        req_wdata = 64'h104;
        tick();
        tick();
        check("full_still_blocked", 64'(req_ready), 64'd0);
        check("full_no_start", 64'(start_cnt - base), 64'd0);
        qspi_idle = 1'b1;
        #1;
        check("full_pop_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_start("wr_order", 32'h10 + 32'(i));
            check("wr_cmd", 64'(qspi_cmd), 64'd1);
            check("wr_wdata", qspi_wdata, 64'h100 + 64'(i));
            qspi_idle = 1'b0;
            tick();
            qspi_idle = 1'b1;
            tick();
            if (WRITE_ACK) begin
                check("wr_ack_valid", 64'(rsp_valid), 64'd1);
                check("wr_ack_rdata", rsp_rdata, 64'd0);
                check("wr_ack_err", 64'(rsp_err), 64'd0);
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
            end else begin
                check("wr_no_rsp", 64'(rsp_valid), 64'd0);
            end
        end
        check("wr_start_cnt", 64'(start_cnt - base), 64'd5);
        check("wr_no_illegal", 64'(err_illegal), 64'd0);

        // Illegal command 7 is dropped, following read issues normally
        base = start_cnt;
        push(3'd7, 32'h70, 64'd0);
        push(3'd3, 32'h80, 64'd0);
        wait_start("ill_rd", 32'h80);
        check("ill_flag", 64'(err_illegal), 64'd1);
        check("ill_rd_cmd", 64'(qspi_cmd), 64'd3);
        qspi_idle = 1'b0;
        tick();
        qspi_rdata = 64'h0123_4567_89AB_CDEF;
        qspi_idle  = 1'b1;
        tick();
        check("ill_rd_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("ill_start_cnt", 64'(start_cnt - base), 64'd1);

        // Timeout: manager never returns idle
        push(3'd6, 32'h100, 64'd0);
        wait_start("tmo", 32'h100);
        qspi_idle = 1'b0;
        repeat (1024) tick();
        check("tmo_not_yet_valid", 64'(rsp_valid), 64'd0);
        check("tmo_not_yet_flag", 64'(err_timeout), 64'd0);
        tick();
        check("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
        check("tmo_flag", 64'(err_timeout), 64'd1);
        check("tmo_rsp_err", 64'(rsp_err), 64'd1);
        check("tmo_rsp_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("tmo_illegal_sticky", 64'(err_illegal), 64'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("tmo_flag_sticky", 64'(err_timeout), 64'd1);
        qspi_idle = 1'b1;
        tick();

        // Reset during WAIT with three requests queued
        push(3'd3, 32'h200, 64'd0);
        wait_start("mid", 32'h200);
        qspi_idle = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            push(3'd4, 32'h210 + 32'(i), 64'd0);
        end
        check("mid_req_ready", 64'(req_ready), 64'd1);
        reset = 1'b1;
        tick();
        tick();
        check("mrst_req_ready", 64'(req_ready), 64'd0);
        check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mrst_rsp_err", 64'(rsp_err), 64'd0);
        check("mrst_rsp_rdata", rsp_rdata, 64'd0);
        check("mrst_qspi_start", 64'(qspi_start), 64'd0);
        check("mrst_qspi_fields", 64'({qspi_cmd, qspi_bankmap, qspi_addr}), 64'd0);
        check("mrst_qspi_wdata", qspi_wdata, 64'd0);
        check("mrst_err_flags", 64'({err_illegal, err_timeout}), 64'd0);
        reset     = 1'b0;
        qspi_idle = 1'b1;
        #1;
        check("mrst_rel_ready", 64'(req_ready), 64'd1);
        base = start_cnt;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("mrst_fifo_empty", 64'(start_cnt - base), 64'd0);
        check("mrst_no_rsp", 64'(rsp_valid), 64'd0);
        push(3'd3, 32'h300, 64'd0);
        wait_start("post_rst", 32'h300);
        qspi_idle = 1'b0;
        tick();
        qspi_idle = 1'b1;
        tick();
        check("post_rst_rsp", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
